audio_mixer: RTL and testbench

//  Parametrised stereo mixer for the board top level. It mixes CH sources into one signed stereo pair:

---
 rtl/audio_mixer_pkg.sv | 35 +++
 rtl/audio_dsg.sv | 35 +++
 rtl/audio_mixer.sv | 151 +++++++++++++++
 tb/tb_audio_mixer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the stereo mixer: FSM state encoding,
// input-format conversion and output saturation.
package audio_mixer_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_t;

   // Widest value the generic helpers handle.
   localparam int MAXW = 64;

   // Convert a w-bit sample to signed: offset-binary input gets its MSB flipped,
   // then the result is sign-extended from bit w-1 to MAXW bits.
   function automatic logic signed [MAXW-1:0] to_signed(input logic [MAXW-1:0] sample,
                                                         input logic fmt, input int w);
      logic [MAXW-1:0] t;
      t = sample;
      if (!fmt) t[w-1] = ~t[w-1];
      for (int i = 0; i < MAXW; i++) begin
         if (i >= w) t[i] = t[w-1];
      end
      return $signed(t);
   endfunction

   // Clamp m to the signed ow-bit range. Returns {clipped, value}; the caller
   // keeps the low ow bits of value.
   function automatic logic [MAXW:0] sat(input logic signed [MAXW-1:0] m, input int ow);
      logic signed [MAXW-1:0] hi;
      logic signed [MAXW-1:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      if (m > hi) return {1'b1, hi};
      else if (m < lo) return {1'b1, lo};
      return {1'b0, m};
   endfunction

endpackage

// File: rtl/audio_dsg.sv
// First-order delta-sigma modulator for one output side. The signed sample is
// turned into offset binary and added into a W-bit accumulator every clock;
// the carry out is the 1-bit output, so its density tracks the sample level.
module audio_dsg
   import audio_mixer_pkg::*;
#(
   parameter int W = 16
)
(
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic         dout
);

   logic [W-1:0] acc;
   logic [W:0]   sum;

   // Offset-binary sample plus running accumulator, carry in the top bit
   always_comb begin
      sum = {1'b0, acc} + {1'b0, ~din[W-1], din[W-2:0]};
   end

   // Accumulator and carry register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         dout <= 1'b0;
      end else begin
         acc  <= sum[W-1:0];
         dout <= sum[W];
      end
   end

endmodule

// File: rtl/audio_mixer.sv
// Time-multiplexed stereo mixer: CH stereo sources, per-channel format,
// volume and mute, one channel per clock through a single MAC, saturating
// output. Optional delta-sigma bit outputs when AUDIO_MIXER_DSG_EN is defined.
module audio_mixer
   import audio_mixer_pkg::*;
#(
   parameter int CH = 4,
   parameter int IW = 16,
   parameter int VW = 4,
   parameter int OW = 16
)
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ce,
   input  logic [CH*IW-1:0]     inL,
   input  logic [CH*IW-1:0]     inR,
   input  logic [CH-1:0]        fmt,
   input  logic [CH*VW-1:0]     vol,
   input  logic [CH-1:0]        mute,
   output logic signed [OW-1:0] outL,
   output logic signed [OW-1:0] outR,
   output logic                 valid,
   output logic                 busy,
   output logic [1:0]           clip,
   output logic                 overrun,
   output logic                 dsgL,
   output logic                 dsgR
);

   // Accumulator sized so CH full-scale products never wrap.
   localparam int AW = IW + VW + 1 + $clog2(CH);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam int PW = IW + VW + 1;

   state_t                 state, nstate;
   logic [CW-1:0]          ch;
   logic [CH*IW-1:0]       inl_p0, inr_p0;
   logic [CH-1:0]          fmt_p0, mute_p0;
   logic [CH*VW-1:0]       vol_p0;
   logic signed [AW-1:0]   accl_p1, accr_p1;
   logic signed [MAXW-1:0] tl, tr;
   logic signed [IW-1:0]   sl, sr;
   logic signed [VW:0]     gain;
   logic signed [PW-1:0]   pl, pr;
   logic signed [AW-1:0]   ml, mr;
   logic [MAXW:0]          satl, satr;
   logic                   vld_p2;
   logic                   unused_bits;

   // Next state, busy and overrun
   always_comb begin
      nstate  = state;
      busy    = (state != IDLE);
      overrun = ce && (state != IDLE);
      case (state)
         IDLE:    if (ce) nstate = LOAD;
         LOAD:    nstate = ACC;
         ACC:     if (ch == CW'(CH - 1)) nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   // Frame snapshot on an accepted ce (data only)
   always_ff @(posedge clock) begin
      if (state == IDLE && ce) begin
         inl_p0  <= inL;
         inr_p0  <= inR;
         fmt_p0  <= fmt;
         vol_p0  <= vol;
         mute_p0 <= mute;
      end
   end

   // Current channel: format conversion, gain, mute; frame result saturation
   always_comb begin
      tl   = to_signed(MAXW'(inl_p0[ch*IW +: IW]), fmt_p0[ch], IW);
      tr   = to_signed(MAXW'(inr_p0[ch*IW +: IW]), fmt_p0[ch], IW);
      sl   = tl[IW-1:0];
      sr   = tr[IW-1:0];
      gain = $signed({1'b0, vol_p0[ch*VW +: VW]});
      if (mute_p0[ch]) begin
         pl = '0;
         pr = '0;
      end else begin
         pl = sl * gain;
         pr = sr * gain;
      end
      ml   = accl_p1 >>> VW;
      mr   = accr_p1 >>> VW;
      satl = sat(MAXW'(ml), OW);
      satr = sat(MAXW'(mr), OW);
   end

   assign unused_bits = ^{tl[MAXW-1:IW], tr[MAXW-1:IW], satl[MAXW-1:OW], satr[MAXW-1:OW]};

   // ---- stage p1: multiply-accumulate ----
   // Accumulators cleared in LOAD, one product added per ACC clock
   always_ff @(posedge clock) begin
      if (state == LOAD) begin
         accl_p1 <= '0;
         accr_p1 <= '0;
      end else if (state == ACC) begin
         accl_p1 <= accl_p1 + AW'(pl);
         accr_p1 <= accr_p1 + AW'(pr);
      end
   end

   // ---- stage p2: saturated output registers ----
   // Channel counter, held outputs, clip flags and valid pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ch     <= '0;
         outL   <= '0;
         outR   <= '0;
         clip   <= 2'b00;
         vld_p2 <= 1'b0;
      end else begin
         vld_p2 <= 1'b0;
         case (state)
            LOAD: ch <= '0;
            ACC:  if (ch != CW'(CH - 1)) ch <= ch + 1'b1;
            DONE: begin
               outL   <= satl[OW-1:0];
               outR   <= satr[OW-1:0];
               clip   <= {satr[MAXW], satl[MAXW]};
               vld_p2 <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign valid = vld_p2;

`ifdef AUDIO_MIXER_DSG_EN
   audio_dsg #(.W(OW)) u_dsgl (.clock(clock), .reset(reset), .din(outL), .dout(dsgL));
   audio_dsg #(.W(OW)) u_dsgr (.clock(clock), .reset(reset), .din(outR), .dout(dsgR));
`else
   assign dsgL = 1'b0;
   assign dsgR = 1'b0;
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer (CH=4, IW=16, VW=4, OW=16): directed frames with
// literal expectations plus randomized traffic against a behavioural model.
module tb_audio_mixer;

   localparam int CH = 4;
   localparam int IW = 16;
   localparam int VW = 4;
   localparam int OW = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              ce = 1'b0;
   logic [CH*IW-1:0]  inL = '0, inR = '0;
   logic [CH-1:0]     fmt = '0, mute = '0;
   logic [CH*VW-1:0]  vol = '0;
   logic [OW-1:0]     outL, outR;
   logic              valid, busy, overrun, dsgL, dsgR;
   logic [1:0]        clip;

   int checks = 0;
   int errors = 0;
   int vld_cnt = 0;
   bit mon_en = 0;

   // model state
   int          phase = -1;
   logic [15:0] e_l = '0, e_r = '0, p_l = '0, p_r = '0;
   logic [1:0]  e_clip = '0, p_clip = '0;
   bit          e_vld = 0;

   always #5 clock = ~clock;

   audio_mixer #(.CH(CH), .IW(IW), .VW(VW), .OW(OW)) dut (
      .clock(clock), .reset(reset), .ce(ce), .inL(inL), .inR(inR),
      .fmt(fmt), .vol(vol), .mute(mute), .outL(outL), .outR(outR),
      .valid(valid), .busy(busy), .clip(clip), .overrun(overrun),
      .dsgL(dsgL), .dsgR(dsgR)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Mix one side from the frame's rules: signed value per channel, times
   // vol/16, floor, clamp to 16-bit signed. Returns {clipped, sample}.
   function automatic logic [16:0] mix_side(input logic [CH*IW-1:0] d, input logic [CH-1:0] f,
                                            input logic [CH*VW-1:0] v, input logic [CH-1:0] m);
      longint acc, s, q;
      logic [IW-1:0] x;
      acc = 0;
      for (int n = 0; n < CH; n++) begin
         x = d[n*IW +: IW];
         if (f[n]) s = longint'($signed(x));
         else      s = longint'(x) - 32768;
         if (!m[n]) acc += s * longint'(v[n*VW +: VW]);
      end
      q = acc >>> VW;
      if (q > 32767)  return {1'b1, 16'h7FFF};
      if (q < -32768) return {1'b1, 16'h8000};
      return {1'b0, q[15:0]};
   endfunction

   // Per-cycle compare against the model, then advance the model across the next edge
   always @(negedge clock) begin
      logic [16:0] rl, rr;
      if (mon_en) begin
         if (reset) begin
            phase = -1; e_l = '0; e_r = '0; e_clip = '0; e_vld = 0;
         end
         chk("valid", valid, e_vld);
         if (valid) vld_cnt++;
         chk("outL", outL, e_l);
         chk("outR", outR, e_r);
         chk("clip", clip, e_clip);
         chk("busy", busy, phase >= 0);
         chk("overrun", overrun, ce && phase >= 0);
`ifndef AUDIO_MIXER_DSG_EN
         chk("dsg_off", {dsgR, dsgL}, 2'b00);
`else
         if (reset) chk("dsg_reset", {dsgR, dsgL}, 2'b00);
`endif
         if (!reset) begin
            e_vld = 0;
            if (phase >= 0) begin
               phase++;
               if (phase == CH + 2) begin
                  e_l = p_l; e_r = p_r; e_clip = p_clip; e_vld = 1; phase = -1;
               end
            end else if (ce) begin
               rl = mix_side(inL, fmt, vol, mute);
               rr = mix_side(inR, fmt, vol, mute);
               p_l = rl[15:0]; p_r = rr[15:0]; p_clip = {rr[16], rl[16]};
               phase = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_quiet();
      inL = '0; inR = '0; fmt = '1; vol = '0; mute = '1;
   endtask

   task automatic pulse_ce();
      ce = 1'b1;
      tick();
      ce = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (valid) begin
            lat = i;
            break;
         end
      end
      chk("valid_seen", valid, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, v0, ones;
      logic [16:0] r;

      // model pinned by hand-computed values
      r = mix_side(64'h0000_0000_0000_1000, 4'b0001, 16'h000F, 4'b1110);
      chk("model_gain15", r, {1'b0, 16'h0F00});
      r = mix_side(64'h0000_0000_4000_0000, 4'b0000, 16'h0080, 4'b1101);
      chk("model_unsigned", r, {1'b0, 16'hE000});
      r = mix_side(64'h8000_8000_8000_8000, 4'b1111, 16'hFFFF, 4'b0000);
      chk("model_satneg", r, {1'b1, 16'h8000});

      // 1: reset, then idle
      set_quiet();
      #1 reset = 1'b1;
      tick(); tick();
      mon_en = 1;
      chk("rst_outL", outL, 16'h0000);
      chk("rst_valid_busy", {valid, busy, overrun}, 3'b000);
      tick();
      reset = 1'b0;
      v0 = vld_cnt;
      repeat (100) tick();
      chk("idle_no_valid", vld_cnt - v0, 0);

      // 2: single signed channel, full volume, exact latency
      set_quiet();
      inL[15:0] = 16'h1000; vol[3:0] = 4'd15; mute = 4'b1110;
      pulse_ce();
      wait_valid(lat);
      chk("latency", lat, CH + 2);
      chk("t2_outL", outL, 16'h0F00);
      chk("t2_clip", clip, 2'b00);
      tick();

      // 3: unsigned offset-binary channel, half volume
      set_quiet();
      inL[31:16] = 16'hC000; inR[31:16] = 16'h4000; fmt[1] = 1'b0;
      vol[7:4] = 4'd8; mute = 4'b1101;
      pulse_ce();
      wait_valid(lat);
      chk("t3_outL", outL, 16'h2000);
      chk("t3_outR", outR, 16'hE000);
      tick();

      // 4: saturation both sides, then a silent frame clears clip
      inL = {4{16'h7FFF}}; inR = {4{16'h8000}}; fmt = '1; vol = '1; mute = '0;
      pulse_ce();
      wait_valid(lat);
      chk("t4_outL", outL, 16'h7FFF);
      chk("t4_outR", outR, 16'h8000);
      chk("t4_clip", clip, 2'b11);
      tick();
      set_quiet();
      pulse_ce();
      wait_valid(lat);
      chk("t4_muted", {outR, outL}, 32'h0);
      chk("t4_clip0", clip, 2'b00);
      tick();

      // 5: second ce while busy is an overrun; result from first snapshot
      set_quiet();
      inL[15:0] = 16'h1000; vol[3:0] = 4'd15; mute = 4'b1110;
      ce = 1'b1;
      tick();
      ce = 1'b0;
      tick();
      v0 = vld_cnt;
      inL[15:0] = 16'h2000; vol[3:0] = 4'd3;
      ce = 1'b1;
      @(negedge clock);
      chk("t5_overrun", overrun, 1);
      tick();
      ce = 1'b0;
      wait_valid(lat);
      chk("t5_snapshot", outL, 16'h0F00);
      repeat (10) tick();
      chk("t5_single_valid", vld_cnt - v0, 1);

      // 6: reset 3 clocks into a frame aborts it
      pulse_ce();
      tick(); tick(); tick();
      v0 = vld_cnt;
      reset = 1'b1;
      #1;
      chk("t6_outL", outL, 16'h0000);
      chk("t6_busy", busy, 0);
      tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("t6_no_valid", vld_cnt - v0, 0);

`ifdef AUDIO_MIXER_DSG_EN
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clock);
         if (dsgL) ones++;
      end
      checks++;
      if (ones < 511 || ones > 513) begin
         errors++;
         $display("FAIL dsg_50: got %0d ones, expected 512 +/- 1", ones);
      end
      set_quiet();
      inL[31:0] = 32'h4000_4000; vol[7:0] = 8'h88; mute = 4'b1100;
      tick();
      pulse_ce();
      wait_valid(lat);
      chk("dsg_outL", outL, 16'h4000);
      ones = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clock);
         if (dsgL) ones++;
      end
      checks++;
      if (ones < 767 || ones > 769) begin
         errors++;
         $display("FAIL dsg_75: got %0d ones, expected 768 +/- 1", ones);
      end
`else
      ones = 0;
`endif

      // randomized traffic: inputs change every cycle, random ce, rare reset
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < CH; n++) begin
            case ($urandom_range(0, 4))
               0:       inL[n*IW +: IW] = 16'h7FFF;
               1:       inL[n*IW +: IW] = 16'h8000;
               default: inL[n*IW +: IW] = 16'($urandom);
            endcase
            inR[n*IW +: IW] = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            vol[n*VW +: VW] = 4'($urandom);
            fmt[n]  = 1'($urandom);
            mute[n] = ($urandom_range(0, 3) == 0);
         end
         ce = ($urandom_range(0, 5) == 0);
         reset = (!reset && $urandom_range(0, 299) == 0);
         tick();
      end
      reset = 1'b0;
      ce = 1'b0;
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
